// File: rtl/genie_mem_delay_cfg_if.sv
// Stream, configuration and status signals of the programmable delay line.
// The slave modport is the delay line itself; the master modport is its user.
interface genie_mem_delay_cfg_if #(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 16
);
  localparam int DW = $clog2(MAX_CYCLES + 1);

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic [DW-1:0]    i_delay;
  logic             i_delay_load;
  logic [DW-1:0]    o_delay;
  logic             o_cfg_busy;
  logic [DW-1:0]    o_count;

  modport master (
    output i_data, i_valid, i_ready, i_delay, i_delay_load,
    input  o_ready, o_data, o_valid, o_delay, o_cfg_busy, o_count
  );

  modport slave (
    input  i_data, i_valid, i_ready, i_delay, i_delay_load,
    output o_ready, o_data, o_valid, o_delay, o_cfg_busy, o_count
  );
endinterface

// File: rtl/genie_mem_delay_cfg.sv
// Memory-backed valid/ready delay line with a run-time programmable delay.
// The read and write pointers are kept exactly D slots apart; every enabled
// cycle both advance, so a word written at wrptr is read D enabled cycles
// later. A delay change stops intake, drains the line, then re-seeds pointers.
module genie_mem_delay_cfg #(
  parameter int WIDTH         = 32,
  parameter int MAX_CYCLES    = 16,
  parameter int DEFAULT_DELAY = 4
) (
  input  logic                clk,
  input  logic                reset,
  genie_mem_delay_cfg_if.slave bus
);
  localparam int DW = $clog2(MAX_CYCLES + 1);
  localparam int PW = $clog2(MAX_CYCLES);

  typedef enum logic {
    RUN,
    DRAIN
  } state_e;

  logic [WIDTH-1:0]      mem_q [MAX_CYCLES];
  logic [MAX_CYCLES-1:0] slot_vld_q;
  logic [PW-1:0]         rdptr_q;
  logic [PW-1:0]         wrptr_q;
  logic [DW-1:0]         delay_q;
  logic [DW-1:0]         pend_q;
  logic [DW-1:0]         count_q;
  logic [DW-1:0]         count_d;
  state_e                state_q;

  logic          pipe_en;
  logic          accept;
  logic          xfer;
  logic          out_valid;
  logic [DW-1:0] delay_clamped;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_CYCLES - 1)) ? '0 : p + PW'(1);
  endfunction

  // Write pointer seed for a given delay: delay mod MAX_CYCLES (delay <= MAX_CYCLES).
  function automatic logic [PW-1:0] start_ptr(input logic [DW-1:0] d);
    return (d >= DW'(MAX_CYCLES)) ? '0 : PW'(d);
  endfunction

  // Handshake qualifiers; the whole line moves only when the output slot can move.
  always_comb begin
    out_valid = slot_vld_q[rdptr_q];
    pipe_en   = !out_valid || bus.i_ready;
    accept    = bus.i_valid && pipe_en && (state_q == RUN);
    xfer      = out_valid && bus.i_ready;
  end

  // Saturate the requested delay into the legal 1..MAX_CYCLES range.
  always_comb begin
    delay_clamped = bus.i_delay;
    if (bus.i_delay == '0) begin
      delay_clamped = DW'(1);
    end else if (bus.i_delay > DW'(MAX_CYCLES)) begin
      delay_clamped = DW'(MAX_CYCLES);
    end
  end

  // Words-in-flight count: accepted but not yet taken downstream.
  always_comb begin
    count_d = count_q;
    unique case ({accept, xfer})
      2'b10:   count_d = count_q + DW'(1);
      2'b01:   count_d = count_q - DW'(1);
      default: count_d = count_q;
    endcase
  end

  // Data storage; a same-slot read and write returns the old word.
  always_ff @(posedge clk) begin
    if (pipe_en) begin
      mem_q[wrptr_q] <= bus.i_data;
    end
  end

  // Pointers, slot-valid bits, count and the RUN/DRAIN configuration FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld_q <= '0;
      rdptr_q    <= '0;
      wrptr_q    <= start_ptr(DW'(DEFAULT_DELAY));
      delay_q    <= DW'(DEFAULT_DELAY);
      pend_q     <= DW'(DEFAULT_DELAY);
      count_q    <= '0;
      state_q    <= RUN;
    end else begin
      count_q <= count_d;
      if (pipe_en) begin
        slot_vld_q[wrptr_q] <= accept;
        rdptr_q             <= ptr_inc(rdptr_q);
        wrptr_q             <= ptr_inc(wrptr_q);
      end
      unique case (state_q)
        RUN: begin
          if (bus.i_delay_load) begin
            pend_q  <= delay_clamped;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.i_delay_load) begin
            pend_q <= delay_clamped;
          end else if (count_q == '0) begin
            // Line is empty: re-seed pointers, overriding the normal advance above.
            delay_q    <= pend_q;
            rdptr_q    <= '0;
            wrptr_q    <= start_ptr(pend_q);
            slot_vld_q <= '0;
            state_q    <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.o_valid    = out_valid;
  assign bus.o_data     = mem_q[rdptr_q];
  assign bus.o_ready    = pipe_en && (state_q == RUN);
  assign bus.o_delay    = delay_q;
  assign bus.o_cfg_busy = (state_q == DRAIN);
  assign bus.o_count    = count_q;
endmodule

// File: tb/tb_genie_mem_delay_cfg.sv
// Randomized bench for genie_mem_delay_cfg. The reference keeps each accepted
// word in a FIFO with a countdown of enabled cycles until it is due out.
module tb_genie_mem_delay_cfg;
  localparam int WIDTH      = 32;
  localparam int MAX_CYCLES = 16;
  localparam int DEF_DELAY  = 4;

  logic clk;
  logic reset;

  genie_mem_delay_cfg_if #(.WIDTH(WIDTH), .MAX_CYCLES(MAX_CYCLES)) bus ();

  genie_mem_delay_cfg #(
    .WIDTH(WIDTH),
    .MAX_CYCLES(MAX_CYCLES),
    .DEFAULT_DELAY(DEF_DELAY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          rem;
  } ent_t;

  ent_t q[$];
  int   m_delay;
  int   m_pend;
  bit   m_busy;
  int   n_checks;
  int   n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(input int d);
    if (d == 0) return 1;
    if (d > MAX_CYCLES) return MAX_CYCLES;
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    m_delay = DEF_DELAY;
    m_pend  = DEF_DELAY;
    m_busy  = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance the model, cross the edge.
  task automatic step(input bit iv, input logic [31:0] d, input bit ir, input bit ld, input int dl);
    bit exp_valid;
    bit pe;
    bit er;
    bit acc;
    int cnt_before;
    bus.i_valid      = iv;
    bus.i_data       = d;
    bus.i_ready      = ir;
    bus.i_delay_load = ld;
    bus.i_delay      = 5'(dl);
    @(negedge clk);
    exp_valid  = (q.size() > 0) && (q[0].rem == 0);
    pe         = !exp_valid || ir;
    er         = pe && !m_busy;
    acc        = iv && er;
    cnt_before = q.size();
    chk("o_valid", 32'(bus.o_valid), 32'(exp_valid));
    chk("o_ready", 32'(bus.o_ready), 32'(er));
    chk("o_count", 32'(bus.o_count), 32'(cnt_before));
    chk("o_delay", 32'(bus.o_delay), 32'(m_delay));
    chk("o_cfg_busy", 32'(bus.o_cfg_busy), 32'(m_busy));
    if (exp_valid) chk("o_data", bus.o_data, q[0].data);
    if (pe) begin
      if (exp_valid) void'(q.pop_front());
      foreach (q[k]) if (q[k].rem > 0) q[k].rem--;
      if (acc) q.push_back('{data: d, rem: m_delay - 1});
    end
    if (!m_busy) begin
      if (ld) begin
        m_pend = clamp(dl);
        m_busy = 1'b1;
      end
    end else if (ld) begin
      m_pend = clamp(dl);
    end else if (cnt_before == 0) begin
      m_delay = m_pend;
      m_busy  = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 0);
  endtask

  // Asynchronous reset applied between edges; outputs checked while it is held.
  task automatic do_reset();
    reset            = 1'b1;
    bus.i_valid      = 1'b0;
    bus.i_ready      = 1'b1;
    bus.i_delay_load = 1'b0;
    bus.i_delay      = '0;
    bus.i_data       = '0;
    model_reset();
    #2;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_count", 32'(bus.o_count), 32'd0);
    chk("rst_o_cfg_busy", 32'(bus.o_cfg_busy), 32'd0);
    chk("rst_o_delay", 32'(bus.o_delay), 32'(DEF_DELAY));
    chk("rst_o_ready", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    do_reset();

    // T1: back-to-back stream at the default delay
    for (int i = 0; i < 8; i++) step(1'b1, 32'h10 + 32'(i), 1'b1, 1'b0, 0);
    idle(8);

    // T2: three-cycle downstream stall mid-stream
    for (int i = 0; i < 10; i++) step(1'b1, 32'h20 + 32'(i), !(i >= 4 && i < 7), 1'b0, 0);
    idle(10);

    // T3: maximum delay on an empty line
    step(1'b0, 32'h0, 1'b1, 1'b1, MAX_CYCLES);
    idle(3);
    step(1'b1, 32'h30, 1'b1, 1'b0, 0);
    idle(20);

    // T4: shorten the delay while words are in flight
    step(1'b0, 32'h0, 1'b1, 1'b1, 4);
    idle(3);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + 32'(i), 1'b1, 1'b0, 0);
    step(1'b1, 32'h43, 1'b1, 1'b1, 2);
    for (int i = 0; i < 12; i++) step(1'b1, 32'h44 + 32'(i), 1'b1, 1'b0, 0);
    idle(6);

    // T5: clamping, minimum delay, and last-load-wins during drain
    step(1'b0, 32'h0, 1'b1, 1'b1, 0);
    idle(3);
    step(1'b1, 32'h50, 1'b1, 1'b0, 0);
    step(1'b1, 32'h51, 1'b0, 1'b0, 0);
    idle(3);
    step(1'b0, 32'h0, 1'b1, 1'b1, 31);
    idle(3);
    step(1'b0, 32'h0, 1'b1, 1'b1, 3);
    step(1'b0, 32'h0, 1'b1, 1'b1, 7);
    idle(3);

    // T6: reset while draining
    for (int i = 0; i < 3; i++) step(1'b1, 32'h60 + 32'(i), 1'b1, 1'b0, 0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 9);
    step(1'b0, 32'h0, 1'b1, 1'b0, 0);
    do_reset();
    idle(2);

    // Random traffic, stalls and reconfiguration, with one reset midway
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) != 0,
           $urandom_range(0, 39) == 0, int'($urandom_range(0, 31)));
    end
    idle(MAX_CYCLES + 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
